// File: rtl/cpu_complex_sequencer.sv
// cpu_complex_sequencer
//   Sequences the shared multi-cycle multiply and divide units for M-extension
//   ops issued by execute. It latches the operands of a tagged request, holds
//   them for the unit latency, then registers the selected result word and
//   reports completion by updating o_tag. A request is complete when
//   o_tag == i_tag.
//
// Ports
//   i_clock, i_reset        clock; synchronous active-high reset
//   i_request/i_tag/i_op    complex op presented by execute (held until done)
//   i_rs1, i_rs2            source operands, sampled in the accept cycle only
//   o_busy                  combinational stall to execute
//   o_op1, o_op2            registered operands to the multiplier and divider
//   o_mul_signed            multiplier signed mode (MUL/MULH)
//   o_div_signed            divider signed mode (DIV/REM)
//   i_mul_result            64-bit product from the multiplier
//   i_div_result            quotient from the divider
//   i_div_remainder         remainder from the divider
//   o_valid                 one-cycle completion pulse
//   o_tag, o_result         tag/result of the last completed op (held)
//   o_fault                 sticky illegal-op flag, cleared only by reset
//
// Configuration
//   CPU_COMPLEX_DIV_ZERO_FASTPATH_EN: when defined, a divide with i_rs2 == 0
//   completes on its accept edge (quotient all ones, remainder i_rs1) instead
//   of waiting out the divider latency.

module cpu_complex_sequencer #(
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_request,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [2:0]           i_op,
  input  logic [31:0]          i_rs1,
  input  logic [31:0]          i_rs2,
  output logic                 o_busy,
  output logic [31:0]          o_op1,
  output logic [31:0]          o_op2,
  output logic                 o_mul_signed,
  output logic                 o_div_signed,
  input  logic [63:0]          i_mul_result,
  input  logic [31:0]          i_div_result,
  input  logic [31:0]          i_div_remainder,
  output logic                 o_valid,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [31:0]          o_result,
  output logic                 o_fault
);

  localparam int unsigned MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       count, count_nxt;
  logic [2:0]             op_q, op_nxt;
  logic [TAG_WIDTH-1:0]   tag_q, tag_nxt;
  logic [31:0]            op1_nxt, op2_nxt, result_nxt;
  logic                   mul_signed_nxt, div_signed_nxt;
  logic                   valid_nxt, fault_nxt;
  logic [TAG_WIDTH-1:0]   o_tag_nxt;
  logic                   new_req_c;

  // A request whose tag already matches o_tag has completed and is ignored.
  assign new_req_c = i_request && (i_tag != o_tag);
  assign o_busy    = (state != IDLE) || new_req_c;

  // State and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      count        <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      o_op1        <= '0;
      o_op2        <= '0;
      o_mul_signed <= 1'b0;
      o_div_signed <= 1'b0;
      o_valid      <= 1'b0;
      o_tag        <= '0;
      o_result     <= '0;
      o_fault      <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      op_q         <= op_nxt;
      tag_q        <= tag_nxt;
      o_op1        <= op1_nxt;
      o_op2        <= op2_nxt;
      o_mul_signed <= mul_signed_nxt;
      o_div_signed <= div_signed_nxt;
      o_valid      <= valid_nxt;
      o_tag        <= o_tag_nxt;
      o_result     <= result_nxt;
      o_fault      <= fault_nxt;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    op_nxt         = op_q;
    tag_nxt        = tag_q;
    op1_nxt        = o_op1;
    op2_nxt        = o_op2;
    mul_signed_nxt = o_mul_signed;
    div_signed_nxt = o_div_signed;
    valid_nxt      = 1'b0;
    o_tag_nxt      = o_tag;
    result_nxt     = o_result;
    fault_nxt      = o_fault;

    unique case (state)
      IDLE: begin
        if (new_req_c) begin
          if (i_op == 3'd3) begin
            fault_nxt = 1'b1;
          end else begin
            op1_nxt        = i_rs1;
            op2_nxt        = i_rs2;
            op_nxt         = i_op;
            tag_nxt        = i_tag;
            mul_signed_nxt = (i_op == 3'd0) || (i_op == 3'd1);
            div_signed_nxt = (i_op == 3'd4) || (i_op == 3'd6);
            count_nxt      = '0;
`ifdef CPU_COMPLEX_DIV_ZERO_FASTPATH_EN
            // Divide by zero has a fixed answer, so skip the divider entirely.
            if (i_op[2] && (i_rs2 == 32'd0)) begin
              valid_nxt  = 1'b1;
              o_tag_nxt  = i_tag;
              result_nxt = i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
            end else begin
              state_nxt = i_op[2] ? DIV_WAIT : MUL_WAIT;
            end
`else
            state_nxt = i_op[2] ? DIV_WAIT : MUL_WAIT;
`endif
          end
        end
      end

      MUL_WAIT: begin
        if (count == MUL_LAST) begin
          valid_nxt  = 1'b1;
          o_tag_nxt  = tag_q;
          // MUL takes the low word; MULH/MULHU the high word.
          result_nxt = (op_q == 3'd0) ? i_mul_result[31:0] : i_mul_result[63:32];
          state_nxt  = IDLE;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      DIV_WAIT: begin
        if (count == DIV_LAST) begin
          valid_nxt  = 1'b1;
          o_tag_nxt  = tag_q;
          // op bit 1 separates REM/REMU from DIV/DIVU.
          result_nxt = op_q[1] ? i_div_remainder : i_div_result;
          state_nxt  = IDLE;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
